// File: rtl/chip8_draw_engine.sv
// rtl/chip8_draw_engine.sv - CHIP-8 64x32 framebuffer owner executing CLS and DRW opcodes
module chip8_draw_engine #(
  parameter int WRAP   = 0,
  parameter int ADDR_W = 12
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [7:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [3:0]        cmd_n,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic [7:0]        mem_rd_data,
  output logic              done,
  output logic              collision,
  output logic              busy,
  output logic [0:2047]     flat_video_memory
);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, WRITE, FIN} state_t;

  state_t            state, state_nxt;
  logic [5:0]        x0;
  logic [4:0]        y0;
  logic [3:0]        n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        row;
  logic [4:0]        row_nxt;
  logic [7:0]        data_q;
  logic [4:0]        py;
  logic [5:0]        y_next;
  logic [6:0]        px;
  logic [0:63]       mask;
  logic [0:63]       cur_row;
  logic              unused_bits;

  // Start coordinates always wrap, so the high bits of VX/VY never matter.
  assign unused_bits = ^{cmd_x[7:6], cmd_y[7:5]};

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == FIN);
  assign mem_rd_req  = (state == FETCH);
  assign mem_rd_addr = (state == FETCH) ? addr_q + ADDR_W'(row) : '0;

  assign row_nxt = row + 5'd1;
  assign py      = y0 + row;
  assign y_next  = {1'b0, y0} + {1'b0, row_nxt};
  assign cur_row = flat_video_memory[{py, 6'b0} +: 64];

  // One sprite byte spread across the 64-pixel target row, clipped or wrapped at the right edge.
  always_comb begin
    mask = '0;
    px   = '0;
    for (int c = 0; c < 8; c++) begin
      px = {1'b0, x0} + 7'(c);
      if (data_q[7-c] && (WRAP != 0 || !px[6]))
        mask[px[5:0]] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (cmd_valid) state_nxt = !cmd_op ? CLEAR : (cmd_n == 4'd0) ? FIN : FETCH;
      CLEAR: if (row == 5'd31) state_nxt = FIN;
      FETCH: if (mem_rd_ack) state_nxt = WRITE;
      WRITE: begin
        if (row_nxt == {1'b0, n_q} || (WRAP == 0 && y_next[5]))
          state_nxt = FIN;
        else
          state_nxt = FETCH;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state             <= IDLE;
      x0                <= '0;
      y0                <= '0;
      n_q               <= '0;
      addr_q            <= '0;
      row               <= '0;
      data_q            <= '0;
      collision         <= 1'b0;
      flat_video_memory <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (cmd_valid) begin
          x0     <= cmd_x[5:0];
          y0     <= cmd_y[4:0];
          n_q    <= cmd_n;
          addr_q <= cmd_addr;
          row    <= '0;
          if (cmd_op) collision <= 1'b0;
        end
        CLEAR: begin
          flat_video_memory[{row, 6'b0} +: 64] <= '0;
          row <= row_nxt;
        end
        FETCH: if (mem_rd_ack) data_q <= mem_rd_data;
        WRITE: begin
          flat_video_memory[{py, 6'b0} +: 64] <= cur_row ^ mask;
          collision <= collision | (|(cur_row & mask));
          row       <= row_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
